// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch prefetch queue: issues reads to a variable-latency
// instruction memory and buffers returned words ahead of decode.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   memReq, memAddr     open read transaction and its address
//   memValid, memData   completes the open transaction / returned word
//   stall               decode is not consuming the head entry
//   redirect, redirectPC  taken branch: flush queue, refetch from new PC
//   instrValid, instr   head entry present / head word (0 when empty)
//   pcPlus4             head address + 4 (0 when empty)
//   count               number of occupied queue entries

module fetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     memReq,
    output logic [31:0]              memAddr,
    input  logic                     memValid,
    input  logic [31:0]              memData,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [31:0]              redirectPC,
    output logic                     instrValid,
    output logic [31:0]              instr,
    output logic [31:0]              pcPlus4,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    next_pc_q, next_pc_d;
    logic [31:0]    req_addr_q, req_addr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic [31:0]    fifo_instr_q [DEPTH];
    logic [31:0]    fifo_addr_q  [DEPTH];

    logic           complete;
    logic           enq;
    logic           deq;
    logic [CW-1:0]  count_nf;
    logic           space;
    logic           issue;

    assign memReq     = (state_q == WAIT) || (state_q == DISCARD);
    assign memAddr    = req_addr_q;
    assign instrValid = (count_q != '0);
    assign count      = count_q;

    assign complete = memReq & memValid;

    // A redirect flushes the queue, so it wins over both queue ports.
    assign enq = (state_q == WAIT) & complete & ~redirect;
    assign deq = instrValid & ~stall & ~redirect;

    // Occupancy after this cycle's queue traffic, ignoring a flush.
    // A new request is only opened when its word is guaranteed a slot.
    assign count_nf = count_q + CW'(enq) - CW'(deq);
    assign space    = (count_nf < DEPTH_C);

    assign instr   = instrValid ? fifo_instr_q[rd_ptr_q] : 32'd0;
    assign pcPlus4 = instrValid ? (fifo_addr_q[rd_ptr_q] + 32'd4) : 32'd0;

    always_comb begin
        state_d    = state_q;
        next_pc_d  = next_pc_q;
        req_addr_d = req_addr_q;
        issue      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    next_pc_d = redirectPC;
                end else if (space) begin
                    issue = 1'b1;
                end
            end
            WAIT: begin
                if (redirect) begin
                    next_pc_d = redirectPC;
                    // An uncompleted request cannot be cancelled; its
                    // response is swallowed in DISCARD instead.
                    state_d   = complete ? IDLE : DISCARD;
                end else if (complete) begin
                    if (space) begin
                        issue = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (redirect) begin
                    next_pc_d = redirectPC;
                end
                if (complete) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            req_addr_d = next_pc_q;
            next_pc_d  = next_pc_q + 32'd4;
            state_d    = WAIT;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + AW'(deq);
        wr_ptr_d = wr_ptr_q + AW'(enq);
        count_d  = count_nf;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            next_pc_q  <= RESET_PC;
            req_addr_q <= 32'd0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            next_pc_q  <= next_pc_d;
            req_addr_q <= req_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_instr_q[wr_ptr_q] <= memData;
            fifo_addr_q[wr_ptr_q]  <= req_addr_q;
        end
    end

endmodule
